// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request unit and the motion FSM.
//   motion_t : motion FSM state encoding (STOP/UP/DOWN), 2 bits
//   seq_t    : request-unit sequencer encoding (IDLE/MOVE/DOOR), 2 bits
//   mask_above / mask_below : OR-reduce request bits strictly above/below
//                             a floor index
//   decode_motion : maps the raw 2-bit motion state, 3 -> STOP
package elevator_pkg;

   // Widest floor vector the mask helpers accept; callers zero-extend.
   localparam int unsigned MAX_FLOORS = 32;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } motion_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_MOVE = 2'd1,
      SEQ_DOOR = 2'd2
   } seq_t;

   function automatic logic mask_above(input logic [MAX_FLOORS-1:0] req,
                                       input int unsigned f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < MAX_FLOORS; i++)
         if (i > f) r = r | req[i];
      return r;
   endfunction

   function automatic logic mask_below(input logic [MAX_FLOORS-1:0] req,
                                       input int unsigned f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < MAX_FLOORS; i++)
         if (i < f) r = r | req[i];
      return r;
   endfunction

   function automatic motion_t decode_motion(input logic [1:0] m);
      case (m)
         2'd1:    return UP;
         2'd2:    return DOWN;
         default: return STOP;
      endcase
   endfunction

endpackage

// File: rtl/elevator_request_unit.sv
// Request side of the elevator: latches call buttons, tracks cab floor,
// times door dwell and tells the motion FSM whether calls exist above or
// below the cab.
//   clk             : clock, rising edge
//   rst             : synchronous reset, active low
//   call_btn        : call pulses, bit i = floor i
//   move_state      : motion FSM state (STOP=0, UP=1, DOWN=2, 3 = STOP)
//   requestFromUp   : pending call above current floor (0 while door open)
//   requestFromDown : pending call below current floor (0 while door open)
//   floor           : current cab floor
//   door_open       : high while the door is open
//   pending         : latched, unserved calls
module elevator_request_unit
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS        = 8,
   parameter int unsigned FLOOR_W       = 3,
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLOORS-1:0]  call_btn,
   input  logic [1:0]         move_state,
   output logic               requestFromUp,
   output logic               requestFromDown,
   output logic [FLOOR_W-1:0] floor,
   output logic               door_open,
   output logic [FLOORS-1:0]  pending
);

   localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

   seq_t              seq;
   motion_t           dir;
   motion_t           move_cmd;
   logic [TW-1:0]     travel_cnt;
   logic [DW-1:0]     door_cnt;

   logic [FLOORS-1:0]     here_mask;
   logic [FLOORS-1:0]     next_mask;
   logic [FLOORS-1:0]     clr;
   logic [FLOOR_W-1:0]    next_floor;
   logic                  here_pending;
   logic                  call_here;
   logic                  arrive_pending;
   logic                  at_end;
   logic [MAX_FLOORS-1:0] pend_ext;

   assign move_cmd = decode_motion(move_state);

   assign here_mask    = FLOORS'(1) << floor;
   assign clr          = (seq == SEQ_DOOR) ? here_mask : '0;
   assign here_pending = |(pending & here_mask);
   assign call_here    = |(call_btn & here_mask);

   // Floor the cab will occupy when the current segment ends; saturates
   // at both ends of the shaft.
   always_comb begin
      next_floor = floor;
      if (dir == UP && floor != TOP_FLOOR)
         next_floor = floor + 1'b1;
      else if (dir == DOWN && floor != '0)
         next_floor = floor - 1'b1;
   end

   assign next_mask      = FLOORS'(1) << next_floor;
   assign arrive_pending = |(pending & next_mask);
   assign at_end         = (dir == UP   && next_floor == TOP_FLOOR) ||
                           (dir == DOWN && next_floor == '0);

   assign pend_ext        = MAX_FLOORS'(pending);
   assign requestFromUp   = (seq != SEQ_DOOR) && mask_above(pend_ext, 32'(floor));
   assign requestFromDown = (seq != SEQ_DOOR) && mask_below(pend_ext, 32'(floor));

   // Calls for the open-door floor are cleared every DOOR cycle, so they
   // never accumulate while the cab is being served there.
   always_ff @(posedge clk) begin
      if (!rst)
         pending <= '0;
      else
         pending <= (pending | call_btn) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         seq        <= SEQ_IDLE;
         floor      <= '0;
         travel_cnt <= '0;
         door_cnt   <= '0;
         dir        <= UP;
         door_open  <= 1'b0;
      end else begin
         case (seq)
            SEQ_IDLE: begin
               if (here_pending) begin
                  seq       <= SEQ_DOOR;
                  door_cnt  <= DOOR_LAST;
                  door_open <= 1'b1;
               end else if (move_cmd == UP && floor != TOP_FLOOR) begin
                  seq        <= SEQ_MOVE;
                  dir        <= UP;
                  travel_cnt <= '0;
               end else if (move_cmd == DOWN && floor != '0) begin
                  seq        <= SEQ_MOVE;
                  dir        <= DOWN;
                  travel_cnt <= '0;
               end
            end
            SEQ_MOVE: begin
               // move_cmd is only looked at when a segment completes.
               if (travel_cnt == TRAVEL_LAST) begin
                  floor      <= next_floor;
                  travel_cnt <= '0;
                  if (arrive_pending) begin
                     seq       <= SEQ_DOOR;
                     door_cnt  <= DOOR_LAST;
                     door_open <= 1'b1;
                  end else if (move_cmd == STOP || at_end) begin
                     seq <= SEQ_IDLE;
                  end else begin
                     dir <= move_cmd;
                  end
               end else begin
                  travel_cnt <= travel_cnt + 1'b1;
               end
            end
            SEQ_DOOR: begin
               if (call_here) begin
                  door_cnt <= DOOR_LAST;
               end else if (door_cnt == '0) begin
                  seq       <= SEQ_IDLE;
                  door_open <= 1'b0;
               end else begin
                  door_cnt <= door_cnt - 1'b1;
               end
            end
            default: begin
               seq       <= SEQ_IDLE;
               door_open <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_request_unit.sv
// Directed bench for elevator_request_unit. Expectations are queued when
// stimulus is driven and checked 1 ns after the following rising edge.
module tb_elevator_request_unit;
   import elevator_pkg::*;

   localparam int SEL_FLOOR = 0;
   localparam int SEL_PEND  = 1;
   localparam int SEL_UP    = 2;
   localparam int SEL_DOWN  = 3;
   localparam int SEL_DOOR  = 4;

   logic       clk;
   logic       rst;
   logic [7:0] call_btn;
   logic [1:0] move_state;
   logic       requestFromUp;
   logic       requestFromDown;
   logic [2:0] floor;
   logic       door_open;
   logic [7:0] pending;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   elevator_request_unit #(
      .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
   ) dut (
      .clk(clk), .rst(rst), .call_btn(call_btn), .move_state(move_state),
      .requestFromUp(requestFromUp), .requestFromDown(requestFromDown),
      .floor(floor), .door_open(door_open), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SEL_FLOOR: return 16'(floor);
         SEL_PEND:  return 16'(pending);
         SEL_UP:    return 16'(requestFromUp);
         SEL_DOWN:  return 16'(requestFromDown);
         default:   return 16'(door_open);
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic push_all(input string tag, input logic [2:0] fl,
                           input logic [7:0] pd, input logic up,
                           input logic dn, input logic dr);
      push({tag, "_floor"}, SEL_FLOOR, 16'(fl));
      push({tag, "_pend"},  SEL_PEND,  16'(pd));
      push({tag, "_up"},    SEL_UP,    16'(up));
      push({tag, "_down"},  SEL_DOWN,  16'(dn));
      push({tag, "_door"},  SEL_DOOR,  16'(dr));
   endtask

   task automatic drain();
      exp_t        e;
      logic [15:0] obs;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      rst        = 1'b0;
      call_btn   = '0;
      move_state = 2'd0;

      // Reset held for two cycles
      tick();
      push_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;

      // Bottom boundary: DOWN and the illegal code 3 leave the cab at 0
      move_state = 2'd2;
      push("sat_down_floor", SEL_FLOOR, 16'd0);
      tick();
      move_state = 2'd3;
      push("code3_floor", SEL_FLOOR, 16'd0);
      push("code3_door",  SEL_DOOR,  16'd0);
      tick();
      move_state = 2'd0;
      tick();

      // Call at floor 3 from floor 0
      call_btn = 8'h08;
      push_all("call3", 3'd0, 8'h08, 1'b1, 1'b0, 1'b0);
      tick();
      call_btn   = '0;
      move_state = 2'd1;
      for (int k = 1; k <= 13; k++) begin
         if (k < 13) begin
            push($sformatf("trip3_k%0d", k), SEL_FLOOR, 16'((k - 1) / 4));
            push($sformatf("trip3_door_k%0d", k), SEL_DOOR, 16'd0);
            push($sformatf("trip3_up_k%0d", k), SEL_UP, 16'd1);
         end else begin
            push_all("arrive3", 3'd3, 8'h08, 1'b0, 1'b0, 1'b1);
         end
         tick();
      end
      move_state = 2'd0;
      for (int j = 1; j <= 6; j++) begin
         push_all($sformatf("dwell3_j%0d", j), 3'd3, 8'h00, 1'b0, 1'b0,
                  (j < 6) ? 1'b1 : 1'b0);
         tick();
      end

      // Same-floor call while idle, then door reload from a repeated press
      call_btn = 8'h08;
      push_all("here_call", 3'd3, 8'h08, 1'b0, 1'b0, 1'b0);
      tick();
      call_btn = '0;
      push("here_open", SEL_DOOR, 16'd1);
      push("here_floor", SEL_FLOOR, 16'd3);
      tick();
      push("here_clr", SEL_PEND, 16'h00);
      tick();
      tick();
      tick();
      call_btn = 8'h08;
      push("reload_door", SEL_DOOR, 16'd1);
      push("reload_pend", SEL_PEND, 16'h00);
      tick();
      call_btn = '0;
      for (int j = 1; j <= 6; j++) begin
         push($sformatf("reload_door_j%0d", j), SEL_DOOR, (j < 6) ? 16'd1 : 16'd0);
         push($sformatf("reload_pend_j%0d", j), SEL_PEND, 16'h00);
         tick();
      end

      // Calls above and below at once; go up and serve floor 5
      call_btn = 8'h22;
      push_all("both", 3'd3, 8'h22, 1'b1, 1'b1, 1'b0);
      tick();
      call_btn   = '0;
      move_state = 2'd1;
      for (int k = 1; k <= 9; k++) begin
         if (k < 9)
            push($sformatf("trip5_k%0d", k), SEL_FLOOR, 16'(3 + (k - 1) / 4));
         else
            push_all("arrive5", 3'd5, 8'h22, 1'b0, 1'b0, 1'b1);
         tick();
      end
      move_state = 2'd0;
      for (int j = 1; j <= 6; j++) begin
         push($sformatf("dwell5_door_j%0d", j), SEL_DOOR, (j < 6) ? 16'd1 : 16'd0);
         push($sformatf("dwell5_pend_j%0d", j), SEL_PEND, 16'h02);
         tick();
      end
      push_all("after5", 3'd5, 8'h02, 1'b0, 1'b1, 1'b0);
      tick();

      // Head down, STOP mid-segment: segment completes at floor 4, no door
      move_state = 2'd2;
      for (int k = 1; k <= 3; k++) begin
         push($sformatf("seg_k%0d", k), SEL_FLOOR, 16'd5);
         tick();
      end
      move_state = 2'd0;
      push("seg_k4", SEL_FLOOR, 16'd5);
      tick();
      push_all("seg_done", 3'd4, 8'h02, 1'b0, 1'b1, 1'b0);
      tick();
      push_all("seg_idle", 3'd4, 8'h02, 1'b0, 1'b1, 1'b0);
      tick();

      // Reset while the door is open with calls at 0 and 7 pending
      call_btn = 8'h91;
      push("pre_rst_pend", SEL_PEND, 16'h93);
      tick();
      call_btn = '0;
      push("pre_rst_door", SEL_DOOR, 16'd1);
      tick();
      push_all("in_door", 3'd4, 8'h83, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
      push_all("mid_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      push_all("post_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_request_unit.md
Name: elevator_request_unit

Overview:
- Request side of the elevator motion FSM: latches floor call buttons and tracks the cab's floor position.
- Times door dwell at each served floor.
- Drives requestFromUp / requestFromDown into the motion FSM.
- Consumes the motion FSM's STOP/UP/DOWN state as move_state, closing the loop: calls in, motion state back, requests out.

Parameters:
- FLOORS, 8, number of floors; floor 0 = bottom.
- FLOOR_W, 3, width of the floor index; must satisfy 2**FLOOR_W >= FLOORS.
- TRAVEL_CYCLES, 4, clock cycles to move one floor; minimum 1.
- DOOR_CYCLES, 6, clock cycles the door stays open per service; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- call_btn  input  FLOORS  one-cycle-or-longer call pulses, bit i = floor i.
- move_state  input  2  motion FSM state: STOP=0, UP=1, DOWN=2; 3 treated as STOP.
- requestFromUp  output  1  a pending call exists above the current floor.
- requestFromDown  output  1  a pending call exists below the current floor.
- floor  output  FLOOR_W  current cab floor.
- door_open  output  1  door open (high while in DOOR).
- pending  output  FLOORS  latched, unserved calls.

Behaviour:
- Reset (rst==0 at posedge):
  - pending=0, floor=0, seq=IDLE.
  - travel_cnt=0, door_cnt=0, dir=UP, door_open=0.
  - requestFromUp=0, requestFromDown=0.
- Pending latch, every cycle: pending <= (pending | call_btn) & ~clr.
  - clr = one-hot(floor) while seq==DOOR, else 0.
  - Calls for the current floor are never latched while the door is open.
- Request outputs: combinational from registered state.
  - requestFromUp = (seq!=DOOR) & |(pending bits with index > floor).
  - requestFromDown = (seq!=DOOR) & |(pending bits with index < floor).
  - Both are 0 in DOOR, which forces the motion FSM to STOP on the next edge.
- Sequencer FSM, states IDLE, MOVE, DOOR:
  - IDLE:
    - If pending[floor]: go to DOOR, door_cnt=DOOR_CYCLES-1.
    - Else if move_state==UP and floor<FLOORS-1: go to MOVE, dir=UP, travel_cnt=0.
    - Else if move_state==DOWN and floor>0: go to MOVE, dir=DOWN, travel_cnt=0.
    - Else stay in IDLE.
    - Pending check has priority over movement.
  - MOVE:
    - travel_cnt increments each cycle.
    - At travel_cnt==TRAVEL_CYCLES-1: floor <= floor±1 per dir, travel_cnt=0, then evaluate at the new floor:
      - pending[new floor] -> DOOR, door_cnt=DOOR_CYCLES-1.
      - else move_state==STOP, or at the end floor in dir -> IDLE.
      - else stay in MOVE with dir <= move_state.
    - A segment in progress always completes; move_state changes mid-segment are ignored until the segment ends.
  - DOOR:
    - door_open=1.
    - call_btn[floor]=1 reloads door_cnt=DOOR_CYCLES-1.
    - Otherwise door_cnt decrements; at door_cnt==0 with no reload -> IDLE.
- Latency:
  - Call to pending visible: 1 cycle.
  - Call to request output: 1 cycle.
  - Arrival to door_open: same edge as the floor update.
- Floor is saturating: it never wraps below 0 or above FLOORS-1.
- Simultaneous events:
  - Calls on multiple floors in one cycle are all latched.
  - A call for floor f arriving on the edge where floor becomes f (MOVE arrival) is latched this cycle. It is served at the next IDLE check unless the door opens now for another reason, in which case clr removes it next cycle.
- Reset mid-operation (any state) returns to the reset values at the next edge and drops all pending calls.

Decomposition:
- Shared package elevator_pkg holds:
  - motion encodings STOP/UP/DOWN (2-bit), shared with the motion FSM;
  - sequencer encodings SEQ_IDLE=0, SEQ_MOVE=1, SEQ_DOOR=2.
- No sub-module required.
- Above/below mask reduction is a package function, mask_above(pending, floor) / mask_below(...), reused by the motion FSM bench.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, floor=0, pending=0.
- At floor 0, call_btn=8'b0000_1000 -> next cycle requestFromUp=1, pending=0x08; with move_state=UP, floor reaches 3 after 12 cycles (3×4); door_open=1 for 6 cycles; pending=0 after the first DOOR cycle; requestFromUp=0 throughout.
- At floor 3, IDLE, call_btn[3] -> DOOR after 1 cycle, no motion; during DOOR, pulse call_btn[3] at door cycle 4 -> door stays open 6 more cycles from the pulse, pending[3] stays 0.
- At floor 3, calls at floors 1 and 5 in the same cycle -> requestFromUp=1 and requestFromDown=1 together; driving move_state=UP serves 5 first; afterwards only requestFromDown=1.
- During MOVE at travel_cnt=2 toward floor 4, move_state forced to STOP -> segment completes, floor=4, seq=IDLE, no door unless pending[4].
- Assert rst=0 in DOOR with pending=0x81 -> next cycle pending=0, floor=0, door_open=0, both requests 0.
